mux_scan_sequencer: RTL and testbench
=====================================

Name: mux_scan_sequencer

Overview:
- Sequencer wrapped around the 4:1 structural multiplexer.
- Upstream, it drives the mux select lines address0/address1 through channels 0..3.
- Downstream, it samples the mux output after a programmable settle time and assembles the four sampled bits into one 4-bit word.
- Provides a start/busy/done handshake, so a controller can read all four mux inputs with a single request.

Parameters:
SETTLE_CYCLES, 2, clock cycles each channel's address is held before its sample is taken (legal range 1..15); covers propagation delay of the structural gates.

Ports:
clk  input  1  system clock; all state changes on the rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  scan request; sampled only when idle (busy=0)
continuous  input  1  when 1 at scan completion, a new scan begins immediately
mux_out  input  1  output of the 4:1 multiplexer
address0  output  1  mux select LSB; channel index = {address1,address0}
address1  output  1  mux select MSB
busy  output  1  high while a scan is in progress
done  output  1  one-cycle pulse on the cycle after a scan's final sample
data  output  4  last completed scan result; data[k] = mux input k

Behaviour:
- Reset (asynchronous, takes effect immediately regardless of clk) sets these values:
  - state IDLE, channel index 0, so address1=0 and address0=0;
  - settle counter 0, busy=0, done=0;
  - data=4'b0000 and internal capture register 4'b0000.
- States are IDLE and SCAN.
- IDLE:
  - On a rising edge with start=1: go to SCAN, channel index := 0, counter := 0, busy := 1.
  - Otherwise hold all outputs.
  - The address lines read 00 while idle.
- SCAN, on each rising edge:
  - If counter < SETTLE_CYCLES-1: counter := counter+1, address unchanged.
  - If counter == SETTLE_CYCLES-1: capture[index] := mux_out, then:
    - If index < 3: index := index+1, counter := 0.
    - If index == 3, the scan completes on this edge (see below).
- Scan completion, on the same edge as the final capture:
  - data := {mux_out, capture[2:0]}, done := 1.
  - If continuous=1: stay in SCAN, index := 0, counter := 0, busy stays 1.
  - Otherwise: go to IDLE, busy := 0, index := 0.
- Timing:
  - Each channel is presented for exactly SETTLE_CYCLES cycles.
  - From the start-accept edge to the done-assert edge is 4*SETTLE_CYCLES rising edges.
  - done is high for exactly one cycle.
- Only the value of mux_out at the final edge of each channel's window is captured; glitches earlier in the window have no effect.
- data changes only at completion edges and holds the previous result for the whole scan. It never shows a partially assembled word.
- start while busy=1 is ignored; no queuing.
- start=1 during the done cycle in non-continuous mode is accepted, because the block is IDLE that cycle. The next scan begins with no gap.
- continuous may toggle at any time; it is evaluated only at completion edges. Deasserting it lets the current scan finish normally.
- Reset mid-scan aborts the scan: no done pulse, data returns to 0000, address to 00.
- address0/address1 are registered outputs, glitch-free, and change only on rising edges.

Test Plan (SETTLE_CYCLES=2 unless stated; mux modelled with in0..in3 driving mux_out per the select lines):
- Basic scan, in0..in3 = 1,0,1,1, start pulsed one cycle:
  - Address sequence 00,00,01,01,10,10,11,11, one value per cycle.
  - done pulses 8 edges after the start edge.
  - data=4'b1101, busy=0 afterwards.
  - data is 0000 before completion.
- Start while busy: reissue start at cycle 3 of a scan with inputs 0,1,1,0.
  - Exactly one done pulse, data=4'b0110.
  - No second scan follows.
- Reset mid-scan: assert reset asynchronously (between clock edges) at cycle 5 with a previous data=4'b1101.
  - data=0000, busy=0, address=00, done=0 immediately.
  - After release with no start, nothing changes for 20 cycles.
- Continuous mode: continuous=1, start once, with inputs 1,1,0,0 then changed to 0,0,1,1 after the first done.
  - done pulses every 8 cycles, busy never drops.
  - data goes 0011 then 1100.
  - Clearing continuous stops the block after the current scan completes.
- Settle filtering: mux_out forced to 1 in the first cycle of channel 2's window and 0 in the last, other channels 0.
  - data[2]=0, data=4'b0000.
- SETTLE_CYCLES=1 build, inputs 0,1,0,1:
  - Address changes every cycle.
  - done 4 edges after start, data=4'b1010.
  - Back-to-back start in the done cycle yields a second done 4 edges later.

Source files
------------

// File: rtl/mux_scan_sequencer.sv
// Scan sequencer for the 4:1 structural mux: steps the select lines through
// channels 0..3, samples mux_out at the end of each settle window, publishes a 4-bit word.
module mux_scan_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       continuous,
    input  logic       mux_out,
    output logic       address0,
    output logic       address1,
    output logic       busy,
    output logic       done,
    output logic [3:0] data
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;
    localparam logic [3:0] LAST = 4'(SETTLE_CYCLES - 1);

    logic [0:0] state;
    logic [1:0] idx;
    logic [3:0] cnt;
    logic [3:0] capture;

    // Select lines come straight from the channel register, so they only move on clk edges.
    assign address0 = idx[0];
    assign address1 = idx[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= '0;
            cnt     <= '0;
            capture <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            data    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SCAN;
                        idx   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (cnt != LAST) begin
                        cnt <= cnt + 4'd1;
                    end else begin
                        capture[idx] <= mux_out;
                        cnt          <= '0;
                        if (idx != 2'd3) begin
                            idx <= idx + 2'd1;
                        end else begin
                            // Final bit bypasses capture so data is whole on the completion edge.
                            data <= {mux_out, capture[2:0]};
                            done <= 1'b1;
                            idx  <= '0;
                            if (!continuous) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer: a SETTLE_CYCLES=2 instance and a
// SETTLE_CYCLES=1 instance, each fed by a behavioural 4:1 mux model.
module tb_mux_scan_sequencer;

    logic       clk;
    logic       reset;
    logic       start, continuous;
    logic [3:0] in_a;
    logic       ovr_en, ovr_val;
    logic       mux_a;
    logic       a0, a1, busy, done;
    logic [3:0] data;

    logic       start2, continuous2;
    logic [3:0] in_b;
    logic       mux_b;
    logic       b0, b1, busy2, done2;
    logic [3:0] data2;

    int checks = 0;
    int passed = 0;

    logic [1:0] sel_a, sel_b;
    assign sel_a = {a1, a0};
    assign sel_b = {b1, b0};
    assign mux_a = ovr_en ? ovr_val : in_a[sel_a];
    assign mux_b = in_b[sel_b];

    mux_scan_sequencer #(.SETTLE_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .start(start), .continuous(continuous),
        .mux_out(mux_a), .address0(a0), .address1(a1),
        .busy(busy), .done(done), .data(data)
    );

    mux_scan_sequencer #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .start(start2), .continuous(continuous2),
        .mux_out(mux_b), .address0(b0), .address1(b1),
        .busy(busy2), .done(done2), .data(data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        if (sel_a !== 2'b00) $display("FAIL reset_addr got %b want 00", sel_a); else passed++; checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++; checks++;
        if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++; checks++;
        if (data !== 4'b0000) $display("FAIL reset_data got %b want 0000", data); else passed++; checks++;
        if (data2 !== 4'b0000) $display("FAIL reset_data2 got %b want 0000", data2); else passed++; checks++;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        if (busy !== 1'b0 || sel_a !== 2'b00) $display("FAIL idle_after_reset got busy=%b addr=%b want 0/00", busy, sel_a); else passed++; checks++;
    endtask

    task automatic test_basic();
        logic [1:0] exp_addr;
        in_a = 4'b1101;
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            exp_addr = 2'(i / 2);
            if (sel_a !== exp_addr) $display("FAIL basic_addr[%0d] got %b want %b", i, sel_a, exp_addr); else passed++; checks++;
            if (busy !== 1'b1) $display("FAIL basic_busy[%0d] got %b want 1", i, busy); else passed++; checks++;
            if (done !== 1'b0) $display("FAIL basic_done_early[%0d] got %b want 0", i, done); else passed++; checks++;
            if (data !== 4'b0000) $display("FAIL basic_data_early[%0d] got %b want 0000", i, data); else passed++; checks++;
        end
        @(negedge clk);
        if (done !== 1'b1) $display("FAIL basic_done got %b want 1", done); else passed++; checks++;
        if (data !== 4'b1101) $display("FAIL basic_data got %b want 1101", data); else passed++; checks++;
        if (busy !== 1'b0) $display("FAIL basic_busy_end got %b want 0", busy); else passed++; checks++;
        if (sel_a !== 2'b00) $display("FAIL basic_addr_end got %b want 00", sel_a); else passed++; checks++;
        @(negedge clk);
        if (done !== 1'b0) $display("FAIL basic_done_width got %b want 0", done); else passed++; checks++;
    endtask

    task automatic test_reset_mid();
        int bad;
        if (data !== 4'b1101) $display("FAIL rmid_pre_data got %b want 1101", data); else passed++; checks++;
        in_a = 4'b0000;
        pulse_start();
        repeat (5) @(negedge clk);
        if (sel_a !== 2'b10) $display("FAIL rmid_pre_addr got %b want 10", sel_a); else passed++; checks++;
        #2 reset = 1'b1;
        #1;
        if (data !== 4'b0000) $display("FAIL rmid_data got %b want 0000", data); else passed++; checks++;
        if (busy !== 1'b0) $display("FAIL rmid_busy got %b want 0", busy); else passed++; checks++;
        if (sel_a !== 2'b00) $display("FAIL rmid_addr got %b want 00", sel_a); else passed++; checks++;
        if (done !== 1'b0) $display("FAIL rmid_done got %b want 0", done); else passed++; checks++;
        @(negedge clk); reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0 || sel_a !== 2'b00 || data !== 4'b0000) bad++;
        end
        if (bad != 0) $display("FAIL rmid_quiet got %0d disturbed cycles want 0", bad); else passed++; checks++;
    endtask

    task automatic test_start_while_busy();
        int ndone, first;
        in_a = 4'b0110;
        pulse_start();
        ndone = 0; first = -1;
        for (int i = 1; i <= 30; i++) begin
            if (i == 3) start = 1'b1;
            @(negedge clk);
            if (i == 3) start = 1'b0;
            if (done === 1'b1) begin ndone++; if (first < 0) first = i; end
        end
        if (ndone != 1) $display("FAIL busy_done_count got %0d want 1", ndone); else passed++; checks++;
        if (first != 8) $display("FAIL busy_done_edge got %0d want 8", first); else passed++; checks++;
        if (data !== 4'b0110) $display("FAIL busy_data got %b want 0110", data); else passed++; checks++;
        if (busy !== 1'b0) $display("FAIL busy_idle_end got %b want 0", busy); else passed++; checks++;
    endtask

    task automatic test_continuous();
        logic       exp_done, exp_busy;
        logic [3:0] exp_data;
        in_a = 4'b0011;
        continuous = 1'b1;
        pulse_start();
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            exp_done = (i == 8 || i == 16 || i == 24);
            exp_busy = (i < 24);
            exp_data = (i < 8) ? 4'b0110 : (i < 16) ? 4'b0011 : 4'b1100;
            if (done !== exp_done) $display("FAIL cont_done[%0d] got %b want %b", i, done, exp_done); else passed++; checks++;
            if (busy !== exp_busy) $display("FAIL cont_busy[%0d] got %b want %b", i, busy, exp_busy); else passed++; checks++;
            if (data !== exp_data) $display("FAIL cont_data[%0d] got %b want %b", i, data, exp_data); else passed++; checks++;
            if (i == 8) in_a = 4'b1100;
            if (i == 20) continuous = 1'b0;
        end
    endtask

    task automatic test_settle_filter();
        in_a = 4'b0000;
        ovr_en = 1'b0;
        pulse_start();
        repeat (4) @(negedge clk);
        ovr_en = 1'b1; ovr_val = 1'b1;
        @(negedge clk);
        ovr_val = 1'b0;
        @(negedge clk);
        ovr_en = 1'b0;
        repeat (2) @(negedge clk);
        if (done !== 1'b1) $display("FAIL settle_done got %b want 1", done); else passed++; checks++;
        if (data !== 4'b0000) $display("FAIL settle_glitch_hi got %b want 0000", data); else passed++; checks++;
        @(negedge clk);
        pulse_start();
        repeat (4) @(negedge clk);
        ovr_en = 1'b1; ovr_val = 1'b0;
        @(negedge clk);
        ovr_val = 1'b1;
        @(negedge clk);
        ovr_en = 1'b0;
        repeat (2) @(negedge clk);
        if (data !== 4'b0100) $display("FAIL settle_late_hi got %b want 0100", data); else passed++; checks++;
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_addr;
        in_b = 4'b1010;
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            exp_addr = 2'(i);
            if (sel_b !== exp_addr) $display("FAIL s1_addr[%0d] got %b want %b", i, sel_b, exp_addr); else passed++; checks++;
            if (done2 !== 1'b0) $display("FAIL s1_done_early[%0d] got %b want 0", i, done2); else passed++; checks++;
        end
        @(negedge clk);
        if (done2 !== 1'b1) $display("FAIL s1_done got %b want 1", done2); else passed++; checks++;
        if (data2 !== 4'b1010) $display("FAIL s1_data got %b want 1010", data2); else passed++; checks++;
        if (busy2 !== 1'b0) $display("FAIL s1_busy_done got %b want 0", busy2); else passed++; checks++;
        start2 = 1'b1;
        in_b = 4'b0110;
        @(negedge clk); start2 = 1'b0;
        if (busy2 !== 1'b1) $display("FAIL b2b_busy got %b want 1", busy2); else passed++; checks++;
        repeat (3) @(negedge clk);
        if (done2 !== 1'b0) $display("FAIL b2b_done_early got %b want 0", done2); else passed++; checks++;
        @(negedge clk);
        if (done2 !== 1'b1) $display("FAIL b2b_done got %b want 1", done2); else passed++; checks++;
        if (data2 !== 4'b0110) $display("FAIL b2b_data got %b want 0110", data2); else passed++; checks++;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0; continuous = 1'b0;
        start2 = 1'b0; continuous2 = 1'b0;
        in_a = 4'b0000; in_b = 4'b0000;
        ovr_en = 1'b0; ovr_val = 1'b0;
        test_reset();
        test_basic();
        test_reset_mid();
        test_start_while_busy();
        test_continuous();
        test_settle_filter();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
